tt_sweep_capture: RTL and testbench
===================================

# tt_sweep_capture

Sequential characterisation stage wrapped around a 3-input truth-table gate (e.g. the 0x99 Wolfram-rule gate). It drives the gate's `in1`/`in2`/`in3` through all eight input combinations and holds each for a programmable settle time. It samples the gate's `out` for each combination and assembles the measured 8-bit rule code. It then compares that code against an expected rule and presents the result via a valid/ready handshake.

## Interface
- `SETTLE_CYCLES`, default 4: cycles each input vector is held before sampling; legal range 1..255.
- `EXPECTED_RULE`, default 8'h99: reference rule code for the compare.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a sweep; honoured only in IDLE.
- `in1` out 1: gate input, MSB of vector index.
- `in2` out 1: gate input, middle bit of vector index.
- `in3` out 1: gate input, LSB of vector index.
- `gate_out` in 1: gate output, same clock domain, sampled directly with no synchroniser.
- `busy` out 1: high from start acceptance until the result is consumed.
- `result_valid` out 1: result fields are stable and valid.
- `result_ready` in 1: consumer accepts the result.
- `rule_code` out 8: measured rule; bit k = `gate_out` sampled with {in1,in2,in3} = k.
- `match` out 1: `rule_code == EXPECTED_RULE`.
- `mismatch_mask` out 8: `rule_code ^ EXPECTED_RULE`.

## Operation
- FSM states: IDLE, SETTLE, REPORT.
- IDLE:
  - start=1 at an edge: idx ← 0, settle_cnt ← 0, rule_code ← 0, go to SETTLE.
  - start=0: remain in IDLE.
- SETTLE:
  - {in1,in2,in3} = idx.
  - settle_cnt increments each cycle.
  - On the edge where settle_cnt == SETTLE_CYCLES-1: rule_code[idx] ← gate_out, settle_cnt ← 0.
  - At that edge, if idx == 7 go to REPORT; otherwise idx ← idx+1.
- REPORT:
  - result_valid = 1 and result fields are held.
  - On an edge with result_ready = 1: go to IDLE; rule_code is retained.
- `start` is ignored in SETTLE and REPORT; it neither queues nor restarts a sweep.
- In IDLE and REPORT, {in1,in2,in3} = 3'b000.
- `match` and `mismatch_mask` are combinational from `rule_code`. They are valid whenever result_valid = 1 and after that until the next sweep starts.
- idx is 3 bits and never wraps within a sweep; the idx==7 terminal is checked before the increment.
- settle_cnt width is $clog2(SETTLE_CYCLES+1), minimum 1.

## Timing
- Reset values: state = IDLE, busy = 0, result_valid = 0, rule_code = 8'h00, in1/in2/in3 = 0, idx = 0, settle_cnt = 0, match = (EXPECTED_RULE == 0).
- Reset asserted mid-sweep aborts the sweep immediately and asynchronously; all outputs return to reset values.
- Sweep timing, with start accepted at edge E0 and S = SETTLE_CYCLES:
  - Vector k is driven during cycles after E0+k·S, through edge E0+(k+1)·S.
  - Vector k is sampled at edge E0+(k+1)·S.
  - result_valid rises after edge E0+8·S: 32 cycles for S = 4, 8 cycles for S = 1.
- busy rises after E0. It falls on the same edge that result_valid falls, i.e. the handshake edge.
- If result_ready is already high when REPORT is entered, result_valid is high for exactly one cycle.
- Back-to-back sweeps: start high on the edge after the handshake begins a new sweep. The minimum gap between sweeps is 1 IDLE cycle.
- All outputs are registered except `match` and `mismatch_mask`.

## Structure
- Shared package `tt_sweep_pkg`:
  - state enum (IDLE, SETTLE, REPORT);
  - `VEC_W = 3`, `NUM_VEC = 8`;
  - localparam rule constants, including `RULE_0X99 = 8'h99`.
- One sub-module, `settle_timer`: parameterised down-counter with `load` and `expire` signals, reused by the other gate characterisers.
- The top level contains the FSM, the idx counter, the rule_code register and the compare.

## Test plan
- Gate model = rule 0x99, S = 4: pulse start, hold result_ready = 1. Required: rule_code = 8'h99, match = 1, mismatch_mask = 0, result_valid exactly at cycle 32 after start.
- Gate model = constant 0, EXPECTED_RULE = 8'h99: rule_code = 8'h00, match = 0, mismatch_mask = 8'h99. Vector sequence on {in1,in2,in3} is 0..7, each held 4 cycles.
- result_ready held low for 20 cycles after result_valid: result_valid, rule_code and busy remain stable for all 20 cycles. A start pulse during this window is ignored. The handshake then returns the block to IDLE.
- rst_n asserted during vector 5: all outputs are at reset values immediately. A new start then yields a full, correct sweep; no partial bits from the aborted sweep remain.
- S = 1 with a rule-0x96 model: result_valid at cycle 8 and rule_code = 8'h96. A start issued the cycle after the handshake begins a second sweep with identical results.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table gate characterisers.
package tt_sweep_pkg;

  localparam int VEC_W   = 3;
  localparam int NUM_VEC = 8;

  localparam logic [7:0] RULE_ZERO = 8'h00;
  localparam logic [7:0] RULE_0X96 = 8'h96;
  localparam logic [7:0] RULE_0X99 = 8'h99;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    REPORT = 2'd2
  } state_e;

  function automatic logic is_last_vec(input logic [VEC_W-1:0] idx);
    return idx == VEC_W'(NUM_VEC - 1);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Reloadable down-counter: expire is high on the last cycle of a CYCLES-long hold.
module settle_timer #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = (CYCLES <= 1) ? 1 : $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (en && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps a 3-input gate through all eight vectors, captures its rule code and compares it.
module tt_sweep_capture
  import tt_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECTED_RULE = RULE_0X99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       gate_out,
  output logic       busy,
  output logic       result_valid,
  input  logic       result_ready,
  output logic [7:0] rule_code,
  output logic       match,
  output logic [7:0] mismatch_mask
);

  state_e           state_q;
  logic [VEC_W-1:0] idx_q;
  logic [VEC_W-1:0] vec_q;
  logic [7:0]       rule_code_q;
  logic             busy_q;
  logic             valid_q;

  logic timer_load;
  logic timer_expire;

  // The timer reloads on sweep start and on every sample edge so each vector
  // gets exactly SETTLE_CYCLES cycles of hold.
  assign timer_load = ((state_q == IDLE) && start) ||
                      ((state_q == SETTLE) && timer_expire);

  settle_timer #(
    .CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .en     (state_q == SETTLE),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      vec_q       <= '0;
      rule_code_q <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= SETTLE;
            idx_q       <= '0;
            vec_q       <= '0;
            rule_code_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        SETTLE: begin
          if (timer_expire) begin
            rule_code_q[idx_q] <= gate_out;
            // Terminal test precedes the increment, so idx never wraps.
            if (is_last_vec(idx_q)) begin
              state_q <= REPORT;
              vec_q   <= '0;
              valid_q <= 1'b1;
            end else begin
              idx_q <= idx_q + VEC_W'(1);
              vec_q <= idx_q + VEC_W'(1);
            end
          end
        end
        REPORT: begin
          if (result_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {in1, in2, in3} = vec_q;
  assign busy            = busy_q;
  assign result_valid    = valid_q;
  assign rule_code       = rule_code_q;
  assign match           = (rule_code_q == EXPECTED_RULE);
  assign mismatch_mask   = rule_code_q ^ EXPECTED_RULE;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Self-checking bench: two sweep instances (S=4 / rule 0x99, S=1 / rule 0x96) driving modelled gates.
module tb_tt_sweep_capture;

  logic clk = 1'b0;
  logic rst_n;

  logic       start_a, ready_a, gate_a, in1_a, in2_a, in3_a, busy_a, valid_a, match_a;
  logic [7:0] code_a, mask_a;
  logic       start_b, ready_b, gate_b, in1_b, in2_b, in3_b, busy_b, valid_b, match_b;
  logic [7:0] code_b, mask_b;

  logic [7:0] rule_a, rule_b;
  logic [2:0] sel_a, sel_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Gate models: output is the rule bit selected by {in1,in2,in3}.
  assign sel_a  = {in1_a, in2_a, in3_a};
  assign sel_b  = {in1_b, in2_b, in3_b};
  assign gate_a = rule_a[sel_a];
  assign gate_b = rule_b[sel_b];

  tt_sweep_capture #(.SETTLE_CYCLES(4), .EXPECTED_RULE(8'h99)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .in1(in1_a), .in2(in2_a), .in3(in3_a), .gate_out(gate_a),
    .busy(busy_a), .result_valid(valid_a), .result_ready(ready_a),
    .rule_code(code_a), .match(match_a), .mismatch_mask(mask_a)
  );

  tt_sweep_capture #(.SETTLE_CYCLES(1), .EXPECTED_RULE(8'h96)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .in1(in1_b), .in2(in2_b), .in3(in3_b), .gate_out(gate_b),
    .busy(busy_b), .result_valid(valid_b), .result_ready(ready_b),
    .rule_code(code_b), .match(match_b), .mismatch_mask(mask_b)
  );

  // Instance selector d doubles as its settle length: 4 -> dut_a, 1 -> dut_b.
  function automatic logic [7:0] exp_of(input int d);
    return (d == 4) ? 8'h99 : 8'h96;
  endfunction
  function automatic logic [2:0] vec_of(input int d);
    return (d == 4) ? sel_a : sel_b;
  endfunction
  function automatic logic busy_of(input int d);
    return (d == 4) ? busy_a : busy_b;
  endfunction
  function automatic logic valid_of(input int d);
    return (d == 4) ? valid_a : valid_b;
  endfunction
  function automatic logic [7:0] code_of(input int d);
    return (d == 4) ? code_a : code_b;
  endfunction
  function automatic logic match_of(input int d);
    return (d == 4) ? match_a : match_b;
  endfunction
  function automatic logic [7:0] mask_of(input int d);
    return (d == 4) ? mask_a : mask_b;
  endfunction

  task automatic set_start(input int d, input logic v);
    if (d == 4) start_a = v; else start_b = v;
  endtask
  task automatic set_ready(input int d, input logic v);
    if (d == 4) ready_a = v; else ready_b = v;
  endtask
  task automatic set_rule(input int d, input logic [7:0] r);
    if (d == 4) rule_a = r; else rule_b = r;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input int d, input string tag, input logic [7:0] rule);
    check({tag, " rule_code"},     32'(code_of(d)),  32'(rule));
    check({tag, " match"},         32'(match_of(d)), 32'(rule == exp_of(d)));
    check({tag, " mismatch_mask"}, 32'(mask_of(d)),  32'(rule ^ exp_of(d)));
  endtask

  task automatic check_reset_vals(input int d, input string tag);
    check({tag, " busy"},   32'(busy_of(d)),  32'(0));
    check({tag, " valid"},  32'(valid_of(d)), 32'(0));
    check({tag, " vector"}, 32'(vec_of(d)),   32'(0));
    check_result(d, tag, 8'h00);
  endtask

  // One sweep: start accepted at the next edge, vector k expected in cycles
  // k*S+1 .. (k+1)*S after acceptance, result_valid after edge 8*S.
  // ready_delay = 0 holds result_ready high from the start.
  task automatic run_sweep(input int d, input logic [7:0] rule, input int ready_delay,
                           input string tag);
    int s;
    s = d;
    set_rule(d, rule);
    set_ready(d, ready_delay == 0);
    set_start(d, 1'b1);
    tick();
    set_start(d, 1'b0);
    for (int c = 1; c <= 8 * s; c++) begin
      check({tag, " sweep vector"}, 32'(vec_of(d)),   32'((c - 1) / s));
      check({tag, " sweep valid"},  32'(valid_of(d)), 32'(0));
      check({tag, " sweep busy"},   32'(busy_of(d)),  32'(1));
      if (c == 2) set_start(d, 1'b1);
      if (c == 3) set_start(d, 1'b0);
      tick();
    end
    set_start(d, 1'b0);
    check({tag, " report valid"},  32'(valid_of(d)), 32'(1));
    check({tag, " report busy"},   32'(busy_of(d)),  32'(1));
    check({tag, " report vector"}, 32'(vec_of(d)),   32'(0));
    check_result(d, {tag, " report"}, rule);
    if (ready_delay == 0) begin
      tick();
      check({tag, " one-cycle valid"}, 32'(valid_of(d)), 32'(0));
      check({tag, " busy after hs"},   32'(busy_of(d)),  32'(0));
      check_result(d, {tag, " retained"}, rule);
    end else begin
      for (int i = 0; i < ready_delay; i++) begin
        check({tag, " hold valid"}, 32'(valid_of(d)), 32'(1));
        check({tag, " hold busy"},  32'(busy_of(d)),  32'(1));
        check({tag, " hold code"},  32'(code_of(d)),  32'(rule));
        if (ready_delay >= 3 && i == 1) set_start(d, 1'b1);
        if (ready_delay >= 3 && i == 2) set_start(d, 1'b0);
        tick();
      end
      set_ready(d, 1'b1);
      tick();
      set_ready(d, 1'b0);
      check({tag, " valid after hs"}, 32'(valid_of(d)), 32'(0));
      check({tag, " busy after hs"},  32'(busy_of(d)),  32'(0));
      check_result(d, {tag, " retained"}, rule);
      tick();
      check({tag, " no queued start"}, 32'(busy_of(d)), 32'(0));
      check({tag, " idle vector"},     32'(vec_of(d)),  32'(0));
    end
  endtask

  initial begin
    logic [7:0] r;
    rst_n   = 1'b0;
    start_a = 1'b0; ready_a = 1'b0; rule_a = 8'h00;
    start_b = 1'b0; ready_b = 1'b0; rule_b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals(4, "reset_a");
    check_reset_vals(1, "reset_b");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_sweep(4, 8'h99, 0, "rule99");
    run_sweep(4, 8'h00, 20, "const0_hold20");

    // Abort during vector 5 with a rule whose bits would all show up if retained.
    rule_a  = 8'hFF;
    ready_a = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (5 * 4 + 1) tick();
    check("abort pre vector", 32'(sel_a), 32'(5));
    rst_n = 1'b0;
    #1;
    check_reset_vals(4, "abort");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_reset_vals(4, "post_abort");
    run_sweep(4, 8'h24, 0, "after_abort");

    run_sweep(1, 8'h96, 0, "s1_rule96");
    run_sweep(1, 8'h96, 0, "s1_back2back");

    for (int n = 0; n < 6; n++) begin
      r = 8'($urandom);
      run_sweep(4, r, int'($urandom_range(0, 4)), "rand_a");
      r = 8'($urandom);
      run_sweep(1, r, int'($urandom_range(0, 4)), "rand_b");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
